// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: register map, CONTROL/STATUS bit positions and the
// channel state encoding shared by the timer bank, its channels and the bus.
package timer_bank_pkg;

    localparam logic [1:0] REG_START_VALUE = 2'd0;
    localparam logic [1:0] REG_CURRENT     = 2'd1;
    localparam logic [1:0] REG_CONTROL     = 2'd2;
    localparam logic [1:0] REG_STATUS      = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_PERIODIC = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_CASCADE  = 4;

    localparam int STAT_EXPIRED  = 0;
    localparam int STAT_RUNNING  = 1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/timer_bank_if.sv
// timer_bank_if: register-window bus of the timer bank. The core's
// REGISTER32 decode is the master; the timer bank is the slave.
interface timer_bank_if #(
    parameter int NUM_CHANNELS = 4
);
    import timer_bank_pkg::*;

    localparam int ADDR_W = $clog2(NUM_CHANNELS) + 2;

    logic                    write;
    logic                    cs;
    logic                    prescale_cs;
    logic [ADDR_W-1:0]       reg_addr;
    logic [31:0]             data_in;
    logic [31:0]             data_out;
    logic [NUM_CHANNELS-1:0] irq_pending;
    logic                    irq;

    modport master (
        output write, cs, prescale_cs, reg_addr, data_in,
        input  data_out, irq_pending, irq
    );

    modport slave (
        input  write, cs, prescale_cs, reg_addr, data_in,
        output data_out, irq_pending, irq
    );

endinterface

// File: rtl/timer_bank_channel.sv
// timer_channel: one down-counter with its IDLE/RUN state machine and its
// START_VALUE, CONTROL and STATUS bits. Optional macro TIMER_BANK_CASCADE_EN
// lets a channel count on the previous channel's expiry pulse.
module timer_channel import timer_bank_pkg::*; #(
    parameter int WIDTH         = 32,
    parameter bit ALLOW_CASCADE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        countTick_i,
    input  logic        cascadeIn_i,
    input  logic        wrEn_i,
    input  logic [1:0]  regSel_i,
    input  logic [31:0] wrData_i,
    output logic [31:0] rdData_o,
    output logic        expire_o,
    output logic        irqPending_o
);

`ifdef TIMER_BANK_CASCADE_EN
    localparam bit CascadeAllowed = ALLOW_CASCADE;
`else
    localparam bit CascadeAllowed = 1'b0 & ALLOW_CASCADE;
`endif

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] startValue_q, startValue_d;
    logic [WIDTH-1:0] current_q, current_d;
    logic             periodic_q, periodic_d;
    logic             irqEn_q, irqEn_d;
    logic             cascade_q, cascade_d;
    logic             expired_q, expired_d;
    logic             countEn;
    logic             startCmd;
    logic             stopCmd;
    logic             expireEvt;

    assign countEn = cascade_q ? cascadeIn_i : countTick_i;

    // State and register bank update; reset returns everything to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CH_IDLE;
            startValue_q <= '0;
            current_q    <= '0;
            periodic_q   <= 1'b0;
            irqEn_q      <= 1'b0;
            cascade_q    <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            startValue_q <= startValue_d;
            current_q    <= current_d;
            periodic_q   <= periodic_d;
            irqEn_q      <= irqEn_d;
            cascade_q    <= cascade_d;
            expired_q    <= expired_d;
        end
    end

    // Register writes, then STOP > START > counting; expiry set beats W1C.
    always_comb begin
        state_d      = state_q;
        startValue_d = startValue_q;
        current_d    = current_q;
        periodic_d   = periodic_q;
        irqEn_d      = irqEn_q;
        cascade_d    = cascade_q;
        expired_d    = expired_q;
        expireEvt    = 1'b0;
        startCmd     = wrEn_i && (regSel_i == REG_CONTROL) && wrData_i[CTRL_START];
        stopCmd      = wrEn_i && (regSel_i == REG_CONTROL) && wrData_i[CTRL_STOP];

        if (wrEn_i) begin
            case (regSel_i)
                REG_START_VALUE: startValue_d = wrData_i[WIDTH-1:0];
                REG_CONTROL: begin
                    periodic_d = wrData_i[CTRL_PERIODIC];
                    irqEn_d    = wrData_i[CTRL_IRQ_EN];
                    cascade_d  = CascadeAllowed & wrData_i[CTRL_CASCADE];
                end
                REG_STATUS: begin
                    if (wrData_i[STAT_EXPIRED]) expired_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (stopCmd) begin
            state_d = CH_IDLE;
        end else if (startCmd) begin
            state_d   = CH_RUN;
            current_d = startValue_q;
        end else if ((state_q == CH_RUN) && countEn) begin
            if (current_q != '0) begin
                current_d = current_q - WIDTH'(1);
            end else begin
                expireEvt = 1'b1;
                expired_d = 1'b1;
                if (periodic_q) current_d = startValue_q;
                else            state_d   = CH_IDLE;
            end
        end
    end

    // Register read-back, zero-extended to the 32-bit bus.
    always_comb begin
        rdData_o = '0;
        case (regSel_i)
            REG_START_VALUE: rdData_o = 32'(startValue_q);
            REG_CURRENT:     rdData_o = 32'(current_q);
            REG_CONTROL:     rdData_o = 32'({cascade_q, irqEn_q, periodic_q, 2'b00});
            REG_STATUS:      rdData_o = 32'({state_q == CH_RUN, expired_q});
            default:         rdData_o = '0;
        endcase
    end

    assign expire_o     = expireEvt;
    assign irqPending_o = expired_q & irqEn_q;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NUM_CHANNELS down-counters behind one 32-bit register window
// with a shared prescaler. Optional macro TIMER_BANK_CASCADE_EN enables
// channel chaining through CONTROL bit4 (handled in timer_channel).
module timer_bank import timer_bank_pkg::*; #(
    parameter int NUM_CHANNELS   = 4,
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    timer_bank_if.slave  bus
);

    logic                      wrSel_q, wrSel_d;
    logic                      wrPulse;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] preCnt_q, preCnt_d;
    logic                      tick;
    int                        chIdx;
    logic [31:0]               readData;
    logic [NUM_CHANNELS-1:0]   chWrEn;
    logic [NUM_CHANNELS-1:0]   chExpire;
    logic [NUM_CHANNELS-1:0]   chIrq;
    logic [31:0]               chRdData [NUM_CHANNELS];
    logic                      unusedLastExpire;

    assign chIdx            = int'(bus.reg_addr >> 2);
    assign tick             = (preCnt_q == prescale_q);
    assign unusedLastExpire = chExpire[NUM_CHANNELS-1];

    // Strobe history and prescaler registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrSel_q    <= 1'b0;
            prescale_q <= '0;
            preCnt_q   <= '0;
        end else begin
            wrSel_q    <= wrSel_d;
            prescale_q <= prescale_d;
            preCnt_q   <= preCnt_d;
        end
    end

    // First-cycle write detection and the free-running prescale counter.
    always_comb begin
        wrSel_d    = bus.write & (bus.cs | bus.prescale_cs);
        wrPulse    = wrSel_d & ~wrSel_q;
        prescale_d = prescale_q;
        preCnt_d   = tick ? '0 : preCnt_q + PRESCALE_WIDTH'(1);
        if (wrPulse && bus.prescale_cs) begin
            prescale_d = bus.data_in[PRESCALE_WIDTH-1:0];
            preCnt_d   = '0;
        end
    end

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_chan
        logic cascadeIn;

        if (n == 0) begin : g_head
            assign cascadeIn = 1'b0;
        end else begin : g_tail
            assign cascadeIn = chExpire[n-1];
        end

        assign chWrEn[n] = wrPulse & bus.cs & (chIdx == n);

        timer_channel #(
            .WIDTH         (WIDTH),
            .ALLOW_CASCADE (n != 0)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .countTick_i  (tick),
            .cascadeIn_i  (cascadeIn),
            .wrEn_i       (chWrEn[n]),
            .regSel_i     (bus.reg_addr[1:0]),
            .wrData_i     (bus.data_in),
            .rdData_o     (chRdData[n]),
            .expire_o     (chExpire[n]),
            .irqPending_o (chIrq[n])
        );
    end

    // Read mux; out-of-range channels and an unselected window read 0.
    always_comb begin
        readData = '0;
        if (bus.cs) begin
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (chIdx == n) readData = chRdData[n];
            end
        end else if (bus.prescale_cs) begin
            readData = 32'(prescale_q);
        end
    end

    assign bus.data_out    = readData;
    assign bus.irq_pending = chIrq;
    assign bus.irq         = |chIrq;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed, self-checking bench for timer_bank with four
// channels. Expected values are hand-derived cycle by cycle.
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam int NCH = 4;

`ifdef TIMER_BANK_CASCADE_EN
    localparam logic [31:0] CASCADE_READBACK = 32'h10;
`else
    localparam logic [31:0] CASCADE_READBACK = 32'h00;
`endif

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    timer_bank_if #(.NUM_CHANNELS(NCH)) bus ();

    timer_bank #(
        .NUM_CHANNELS   (NCH),
        .WIDTH          (32),
        .PRESCALE_WIDTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] regAddr(input int ch, input logic [1:0] sel);
        return {2'(ch), sel};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One bus write held for 'cycles' clocks, preceded by an idle cycle.
    task automatic applyStimulus(input logic toPrescale, input logic [3:0] addr,
                                 input logic [31:0] data, input int cycles);
        @(negedge clock);
        bus.write       = 1'b1;
        bus.cs          = !toPrescale;
        bus.prescale_cs = toPrescale;
        bus.reg_addr    = addr;
        bus.data_in     = data;
        repeat (cycles) @(negedge clock);
        bus.write       = 1'b0;
        bus.cs          = 1'b0;
        bus.prescale_cs = 1'b0;
    endtask

    task automatic readReg(input string tag, input logic toPrescale,
                           input logic [3:0] addr, input logic [31:0] expected);
        bus.write       = 1'b0;
        bus.cs          = !toPrescale;
        bus.prescale_cs = toPrescale;
        bus.reg_addr    = addr;
        #1;
        checkOutput(tag, bus.data_out, expected);
        bus.cs          = 1'b0;
        bus.prescale_cs = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        for (int ch = 0; ch < NCH; ch++) begin
            @(negedge clock);
            for (int sel = 0; sel < 4; sel++) begin
                readReg($sformatf("%s ch%0d reg%0d", tag, ch, sel), 1'b0,
                        regAddr(ch, 2'(sel)), 32'h0);
            end
        end
        @(negedge clock);
        readReg({tag, " prescale"}, 1'b1, 4'h0, 32'h0);
        checkOutput({tag, " irq"}, 32'(bus.irq), 32'h0);
        checkOutput({tag, " irq_pending"}, 32'(bus.irq_pending), 32'h0);
    endtask

    initial begin
        bus.write       = 1'b0;
        bus.cs          = 1'b0;
        bus.prescale_cs = 1'b0;
        bus.reg_addr    = '0;
        bus.data_in     = '0;
        reset           = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        $display("[TB] reset values");
        checkAllZero("reset");

        $display("[TB] one-shot countdown on ch0");
        applyStimulus(1'b1, 4'h0, 32'd0, 1);
        applyStimulus(1'b0, regAddr(0, REG_START_VALUE), 32'd3, 1);
        applyStimulus(1'b0, regAddr(0, REG_CONTROL), 32'h9, 1);
        readReg("os current 3", 1'b0, regAddr(0, REG_CURRENT), 32'd3);
        readReg("os running", 1'b0, regAddr(0, REG_STATUS), 32'h2);
        readReg("os control", 1'b0, regAddr(0, REG_CONTROL), 32'h8);
        @(negedge clock);
        readReg("os current 2", 1'b0, regAddr(0, REG_CURRENT), 32'd2);
        @(negedge clock);
        readReg("os current 1", 1'b0, regAddr(0, REG_CURRENT), 32'd1);
        @(negedge clock);
        readReg("os current 0", 1'b0, regAddr(0, REG_CURRENT), 32'd0);
        checkOutput("os irq before expiry", 32'(bus.irq), 32'h0);
        @(negedge clock);
        readReg("os expired idle", 1'b0, regAddr(0, REG_STATUS), 32'h1);
        checkOutput("os irq", 32'(bus.irq), 32'h1);
        checkOutput("os irq_pending", 32'(bus.irq_pending), 32'h1);
        @(negedge clock);
        readReg("os current holds", 1'b0, regAddr(0, REG_CURRENT), 32'd0);
        applyStimulus(1'b0, regAddr(0, REG_STATUS), 32'h1, 1);
        readReg("os w1c", 1'b0, regAddr(0, REG_STATUS), 32'h0);
        checkOutput("os irq cleared", 32'(bus.irq), 32'h0);

        $display("[TB] periodic ch1 with prescale 2");
        applyStimulus(1'b1, 4'h0, 32'd2, 1);
        readReg("prescale readback", 1'b1, 4'h0, 32'd2);
        applyStimulus(1'b0, regAddr(1, REG_START_VALUE), 32'd1, 1);
        applyStimulus(1'b0, regAddr(1, REG_CONTROL), 32'h5, 1);
        readReg("per load", 1'b0, regAddr(1, REG_CURRENT), 32'd1);
        repeat (2) @(negedge clock);
        readReg("per first tick", 1'b0, regAddr(1, REG_CURRENT), 32'd0);
        repeat (2) @(negedge clock);
        readReg("per not yet expired", 1'b0, regAddr(1, REG_STATUS), 32'h2);
        @(negedge clock);
        readReg("per expired", 1'b0, regAddr(1, REG_STATUS), 32'h3);
        readReg("per reload", 1'b0, regAddr(1, REG_CURRENT), 32'd1);
        applyStimulus(1'b0, regAddr(1, REG_STATUS), 32'h1, 1);
        readReg("per w1c", 1'b0, regAddr(1, REG_STATUS), 32'h2);
        repeat (2) @(negedge clock);
        applyStimulus(1'b0, regAddr(1, REG_STATUS), 32'h1, 1);
        readReg("per set beats w1c", 1'b0, regAddr(1, REG_STATUS), 32'h3);
        applyStimulus(1'b0, regAddr(1, REG_CONTROL), 32'h2, 1);
        readReg("per stopped", 1'b0, regAddr(1, REG_STATUS), 32'h1);
        repeat (3) @(negedge clock);
        readReg("per frozen", 1'b0, regAddr(1, REG_CURRENT), 32'd1);

        $display("[TB] long write, stop and start-stop on ch2");
        applyStimulus(1'b1, 4'h0, 32'd0, 1);
        applyStimulus(1'b0, regAddr(2, REG_START_VALUE), 32'd20, 1);
        applyStimulus(1'b0, regAddr(2, REG_CONTROL), 32'h1, 5);
        readReg("long write single load", 1'b0, regAddr(2, REG_CURRENT), 32'd16);
        readReg("long write running", 1'b0, regAddr(2, REG_STATUS), 32'h2);
        applyStimulus(1'b0, regAddr(2, REG_CONTROL), 32'h2, 1);
        readReg("stop freezes", 1'b0, regAddr(2, REG_CURRENT), 32'd15);
        readReg("stop idle", 1'b0, regAddr(2, REG_STATUS), 32'h0);
        repeat (3) @(negedge clock);
        readReg("stop still frozen", 1'b0, regAddr(2, REG_CURRENT), 32'd15);
        applyStimulus(1'b0, regAddr(2, REG_CONTROL), 32'h3, 1);
        readReg("start-stop idle", 1'b0, regAddr(2, REG_STATUS), 32'h0);

        $display("[TB] reset while all channels run");
        applyStimulus(1'b1, 4'h0, 32'd5, 1);
        applyStimulus(1'b0, regAddr(0, REG_START_VALUE), 32'd0, 1);
        for (int ch = 1; ch < NCH; ch++) begin
            applyStimulus(1'b0, regAddr(ch, REG_START_VALUE), 32'd50, 1);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            applyStimulus(1'b0, regAddr(ch, REG_CONTROL), 32'hD, 1);
        end
        repeat (8) @(negedge clock);
        readReg("all run ch3", 1'b0, regAddr(3, REG_STATUS), 32'h2);
        checkOutput("all run irq", 32'(bus.irq), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset irq drops", 32'(bus.irq), 32'h0);
        reset = 1'b0;
        checkAllZero("mid reset");

        $display("[TB] CONTROL cascade bit");
        applyStimulus(1'b0, regAddr(1, REG_CONTROL), 32'h10, 1);
        readReg("ch1 cascade bit", 1'b0, regAddr(1, REG_CONTROL), CASCADE_READBACK);
        applyStimulus(1'b0, regAddr(0, REG_CONTROL), 32'h10, 1);
        readReg("ch0 cascade bit", 1'b0, regAddr(0, REG_CONTROL), 32'h0);

`ifdef TIMER_BANK_CASCADE_EN
        $display("[TB] cascade ch1 on ch0 expiries");
        applyStimulus(1'b0, regAddr(1, REG_START_VALUE), 32'd2, 1);
        applyStimulus(1'b0, regAddr(1, REG_CONTROL), 32'h11, 1);
        applyStimulus(1'b0, regAddr(0, REG_CONTROL), 32'h5, 1);
        readReg("casc load", 1'b0, regAddr(1, REG_CURRENT), 32'd2);
        @(negedge clock);
        readReg("casc one", 1'b0, regAddr(1, REG_CURRENT), 32'd1);
        @(negedge clock);
        readReg("casc two", 1'b0, regAddr(1, REG_STATUS), 32'h2);
        @(negedge clock);
        readReg("casc expired", 1'b0, regAddr(1, REG_STATUS), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
